arm_store_checker: RTL and testbench

Synthesizable self-check stage downstream of `arm_top`. It monitors the core's data-memory write port (`MemWrite`, `DataAdr`, `WriteData`) and decides pass or fail for the program on-chip, which lets the FPGA board report results without a simulator. It logs every accepted store into a small FIFO that a debug or display reader drains through a valid/ready handshake. It also keeps a saturating store count and an optional watchdog timeout.

---
 rtl/arm_store_checker_if.sv | 28 ++
 rtl/arm_store_checker.sv | 155 +++++++++++++++
 tb/tb_arm_store_checker.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/arm_store_checker_if.sv
// Bus bundle for arm_store_checker: the core's store port in, the verdict and status out,
// and the log read port. The slave modport is the checker side.
interface arm_store_checker_if;
    logic        mem_write;
    logic [31:0] data_adr;
    logic [31:0] write_data;
    logic        done;
    logic        pass;
    logic [1:0]  fail_code;
    logic        overflow;
    logic [15:0] store_count;
    logic        log_valid;
    logic        log_ready;
    logic [31:0] log_adr;
    logic [31:0] log_data;

    // log handshake: the head entry moves on every rising edge where log_valid && log_ready.
    // log_valid never depends on log_ready. log_adr/log_data are meaningful only while log_valid is 1.
    modport slave (
        input  mem_write, data_adr, write_data, log_ready,
        output done, pass, fail_code, overflow, store_count, log_valid, log_adr, log_data
    );

    modport master (
        output mem_write, data_adr, write_data, log_ready,
        input  done, pass, fail_code, overflow, store_count, log_valid, log_adr, log_data
    );
endinterface

// File: rtl/arm_store_checker.sv
// On-chip pass/fail checker for arm_top data stores, with a store log FIFO and a saturating store count.
// Define STORE_CHECKER_TIMEOUT_EN to build the RUN-state watchdog.
module arm_store_checker #(
    parameter logic [31:0] PASS_ADDR  = 32'd100,
    parameter logic [31:0] PASS_DATA  = 32'd7,
    parameter logic [31:0] ALLOW_ADDR = 32'd96,
    parameter int unsigned TIMEOUT    = 1000,
    parameter int unsigned LOG_DEPTH  = 8
) (
    input  logic               clk,
    input  logic               reset,
    arm_store_checker_if.slave bus,
    output logic [1:0]         o_dbg_state
);
    localparam int unsigned AW = $clog2(LOG_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_BAD     = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_fail_code;
    logic [1:0]  w_fail_code_nxt;
    logic        w_accept;
    logic        w_term_pass;
    logic        w_term_bad;
    logic        w_wd_expire;

    logic [31:0] r_log_adr  [LOG_DEPTH];
    logic [31:0] r_log_data [LOG_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_occ;
    logic          w_full;
    logic          w_pop;
    logic          w_wr_en;
    logic          w_drop;
    logic          r_overflow;
    logic [15:0]   r_store_count;

    // Only stores seen while still running count; later stores are ignored entirely.
    assign w_accept    = (r_state == ST_RUN) && bus.mem_write;
    assign w_term_pass = (bus.data_adr == PASS_ADDR) && (bus.write_data == PASS_DATA);
    assign w_term_bad  = !w_term_pass && (bus.data_adr != ALLOW_ADDR);

`ifdef STORE_CHECKER_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT);
    logic [CW-1:0] r_wd_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wd_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            r_wd_cnt <= r_wd_cnt + CW'(1);
        end
    end

    assign w_wd_expire = (r_state == ST_RUN) && (r_wd_cnt == CW'(TIMEOUT - 1));
`else
    assign w_wd_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            r_fail_code <= FC_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_fail_code <= w_fail_code_nxt;
        end
    end

    // A terminal store in the watchdog's final cycle takes priority over the timeout.
    always_comb begin
        w_state_nxt     = r_state;
        w_fail_code_nxt = r_fail_code;
        if (r_state == ST_RUN) begin
            if (w_accept && w_term_pass) begin
                w_state_nxt = ST_PASS;
            end else if (w_accept && w_term_bad) begin
                w_state_nxt     = ST_FAIL;
                w_fail_code_nxt = FC_BAD;
            end else if (w_wd_expire) begin
                w_state_nxt     = ST_FAIL;
                w_fail_code_nxt = FC_TIMEOUT;
            end
        end
    end

    always_comb begin
        bus.done      = (r_state != ST_RUN);
        bus.pass      = (r_state == ST_PASS);
        bus.fail_code = r_fail_code;
        o_dbg_state   = r_state;
    end

    assign w_full  = (r_occ == (AW+1)'(LOG_DEPTH));
    assign w_pop   = (r_occ != '0) && bus.log_ready;
    // A full log still takes the new entry when the head leaves in the same cycle.
    assign w_wr_en = w_accept && (!w_full || w_pop);
    assign w_drop  = w_accept && w_full && !w_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(LOG_DEPTH); i++) begin
                r_log_adr[i]  <= '0;
                r_log_data[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_wr_en) begin
                r_log_adr[r_wr_ptr]  <= bus.data_adr;
                r_log_data[r_wr_ptr] <= bus.write_data;
                r_wr_ptr             <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_occ <= r_occ + (AW+1)'(1);
                2'b01:   r_occ <= r_occ - (AW+1)'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow    <= 1'b0;
            r_store_count <= '0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_accept && (r_store_count != 16'hFFFF)) begin
                r_store_count <= r_store_count + 16'd1;
            end
        end
    end

    assign bus.overflow    = r_overflow;
    assign bus.store_count = r_store_count;
    assign bus.log_valid   = (r_occ != '0);
    assign bus.log_adr     = r_log_adr[r_rd_ptr];
    assign bus.log_data    = r_log_data[r_rd_ptr];
endmodule

// File: tb/tb_arm_store_checker.sv
// Directed and random checks of arm_store_checker against a queue-based reference model.
// Runs with or without STORE_CHECKER_TIMEOUT_EN; timeout expectations follow the macro.
module tb_arm_store_checker;
  localparam int unsigned TO    = 20;
  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] PA = 32'd100;
  localparam logic [31:0] PD = 32'd7;
  localparam logic [31:0] AA = 32'd96;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  arm_store_checker_if bus ();

  arm_store_checker #(
    .PASS_ADDR (PA),
    .PASS_DATA (PD),
    .ALLOW_ADDR(AA),
    .TIMEOUT   (TO),
    .LOG_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: verdict flags, elapsed RUN cycles, log as a queue of {adr,data}
  bit          m_done;
  bit          m_pass;
  bit [1:0]    m_code;
  bit          m_ovf;
  int          m_count;
  int          m_cycles;
  logic [63:0] m_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_done = 0; m_pass = 0; m_code = 0; m_ovf = 0;
    m_count = 0; m_cycles = 0;
    m_q.delete();
  endtask

  task automatic model_step(input bit mw, input logic [31:0] a, input logic [31:0] d, input bit rdy);
    bit pop;
    bit push;
    pop  = rdy && (m_q.size() != 0);
    push = 0;
    if (!m_done) begin
      if (mw) begin
        push = 1;
        if (m_count < 65535) m_count++;
        if (a == PA && d == PD) begin
          m_done = 1; m_pass = 1;
        end else if (a != AA) begin
          m_done = 1; m_code = 2'b01;
        end
      end
`ifdef STORE_CHECKER_TIMEOUT_EN
      if (!m_done && m_cycles == TO - 1) begin
        m_done = 1; m_code = 2'b10;
      end
`endif
      m_cycles++;
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back({a, d});
      else m_ovf = 1;
    end
  endtask

  task automatic compare_all();
    check("done", bus.done, m_done);
    check("pass", bus.pass, m_pass);
    check("fail_code", bus.fail_code, m_code);
    check("overflow", bus.overflow, m_ovf);
    check("store_count", bus.store_count, m_count);
    check("log_valid", bus.log_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      check("log_adr", bus.log_adr, m_q[0][63:32]);
      check("log_data", bus.log_data, m_q[0][31:0]);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input bit mw, input logic [31:0] a, input logic [31:0] d, input bit rdy);
    bus.mem_write  = mw;
    bus.data_adr   = a;
    bus.write_data = d;
    bus.log_ready  = rdy;
    model_step(mw, a, d, rdy);
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.mem_write  = 0;
    bus.data_adr   = '0;
    bus.write_data = '0;
    bus.log_ready  = 0;
  endtask

  // Asserts reset between edges, checks the asynchronous clear, releases at a falling edge.
  task automatic do_reset();
    reset = 0;
    drive_idle();
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    @(negedge clk);
    reset = 1;
  endtask

  task automatic pass_sequence(input string tag);
    logic [31:0] exp_d[3];
    exp_d[0] = 32'h5; exp_d[1] = 32'hC; exp_d[2] = 32'h7;
    cycle(1, AA, 32'h5, 0);
    cycle(1, AA, 32'hC, 0);
    cycle(1, PA, 32'h7, 0);
    check({tag, "_pass"}, bus.pass, 1);
    check({tag, "_done"}, bus.done, 1);
    check({tag, "_code"}, bus.fail_code, 0);
    check({tag, "_count"}, bus.store_count, 3);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_drain_valid"}, bus.log_valid, 1);
      check({tag, "_drain_adr"}, bus.log_adr, (i == 2) ? PA : AA);
      check({tag, "_drain_data"}, bus.log_data, exp_d[i]);
      cycle(0, '0, '0, 1);
    end
    check({tag, "_drained"}, bus.log_valid, 0);
  endtask

  initial begin
    reset = 1;
    drive_idle();
    #2;
    do_reset();

    // pass sequence, log held then drained in order
    pass_sequence("pass_seq");

    // wrong data at the pass address, later store ignored
    do_reset();
    cycle(1, PA, 32'd6, 0);
    check("wrong_data_done", bus.done, 1);
    check("wrong_data_pass", bus.pass, 0);
    check("wrong_data_code", bus.fail_code, 2'b01);
    cycle(1, PA, 32'd7, 0);
    check("ignored_count", bus.store_count, 1);
    check("ignored_pass", bus.pass, 0);

    // watchdog
    do_reset();
`ifdef STORE_CHECKER_TIMEOUT_EN
    for (int i = 1; i <= int'(TO) + 3; i++) begin
      cycle(0, '0, '0, 0);
      check("wd_done_edge", bus.done, i >= int'(TO));
    end
    check("wd_code", bus.fail_code, 2'b10);
`else
    for (int i = 0; i < 200; i++) cycle(0, '0, '0, 0);
    check("no_wd_done", bus.done, 0);
`endif

    // terminal store in the watchdog's last cycle
    do_reset();
    for (int i = 0; i < int'(TO) - 1; i++) cycle(0, '0, '0, 0);
    cycle(1, PA, PD, 0);
    check("collide_pass", bus.pass, 1);
    check("collide_code", bus.fail_code, 0);

    // allowed store in the watchdog's last cycle: logged, but the timeout still fires
    do_reset();
    for (int i = 0; i < int'(TO) - 1; i++) cycle(0, '0, '0, 0);
    cycle(1, AA, 32'h33, 0);
    check("collide_allow_count", bus.store_count, 1);

    // overflow: first 8 of 10 kept, then push+pop while full
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1, AA, i, 0);
    check("ovf_flag", bus.overflow, 1);
    check("ovf_count", bus.store_count, 10);
    check("ovf_head", bus.log_data, 0);
    cycle(1, AA, 32'd10, 1);
    check("ovf_pp_count", bus.store_count, 11);
    check("ovf_pp_head", bus.log_data, 1);
    for (int i = 0; i < int'(DEPTH); i++) cycle(0, '0, '0, 1);
    check("ovf_empty", bus.log_valid, 0);

    // reset mid-run, then a fresh pass sequence
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, AA, 32'h40 + i, 0);
    #2;
    do_reset();
    pass_sequence("after_reset");

    // random runs
    for (int r = 0; r < 40; r++) begin
      int len;
      do_reset();
      len = $urandom_range(5, 30);
      for (int c = 0; c < len; c++) begin
        int unsigned sel;
        logic [31:0] a;
        logic [31:0] d;
        sel = $urandom_range(0, 9);
        a = (sel < 7) ? AA : (sel < 9) ? PA : $urandom;
        d = ($urandom_range(0, 3) == 0) ? PD : $urandom_range(0, 15);
        cycle(bit'($urandom_range(0, 1)), a, d, $urandom_range(0, 3) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
